// File: rtl/lvt_bank_router_pkg.sv
// Shared defaults and helpers for the LVT bank router and its live value table.
package lvt_pkg;

  localparam int unsigned IndexWidthDef = 8;
  localparam int unsigned DataWidthDef  = 32;
  localparam int unsigned RDef          = 4;
  localparam int unsigned NBitsRDef     = 2;

  // Write port whose bank is recorded when both ports hit the same address or bank.
  localparam int unsigned PORT_PRIO = 1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) res++;
    return res;
  endfunction

endpackage

// File: rtl/lvt_bank_router_if.sv
// Write request, per-bank strobe and LVT read bundle of the bank router.
interface lvt_bank_router_if import lvt_pkg::*; #(
  parameter int unsigned IndexWidth = IndexWidthDef,
  parameter int unsigned DataWidth  = DataWidthDef,
  parameter int unsigned R          = RDef,
  parameter int unsigned NBitsR     = NBitsRDef
);

  logic [1:0]              wr_en;
  logic [IndexWidth-1:0]   wr_addr0, wr_addr1;
  logic [DataWidth-1:0]    wr_data0, wr_data1;
  logic [NBitsR-1:0]       wr_bank0, wr_bank1;
  logic [R-1:0]            bank_we;
  logic [R*IndexWidth-1:0] bank_addr;
  logic [R*DataWidth-1:0]  bank_wdata;
  logic [IndexWidth-1:0]   rd_addr0, rd_addr1;
  logic [NBitsR-1:0]       rd_sel0, rd_sel1;
  logic                    rd_live0, rd_live1;
  logic                    collision;
  logic                    bank_err;

  modport master (
    output wr_en, wr_addr0, wr_addr1, wr_data0, wr_data1, wr_bank0, wr_bank1,
    output rd_addr0, rd_addr1,
    input  bank_we, bank_addr, bank_wdata, rd_sel0, rd_sel1, rd_live0, rd_live1,
    input  collision, bank_err
  );

  modport slave (
    input  wr_en, wr_addr0, wr_addr1, wr_data0, wr_data1, wr_bank0, wr_bank1,
    input  rd_addr0, rd_addr1,
    output bank_we, bank_addr, bank_wdata, rd_sel0, rd_sel1, rd_live0, rd_live1,
    output collision, bank_err
  );

endinterface

// File: rtl/lvt_bank_router_table.sv
// Live value table: 2W/2R storage of bank index plus live bit, registered reads.
module lvt_table import lvt_pkg::*; #(
  parameter int unsigned IndexWidth = IndexWidthDef,
  parameter int unsigned NBitsR     = NBitsRDef
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we0_i,
  input  logic [IndexWidth-1:0] addr0_i,
  input  logic [NBitsR-1:0]     bank0_i,
  input  logic                  we1_i,
  input  logic [IndexWidth-1:0] addr1_i,
  input  logic [NBitsR-1:0]     bank1_i,
  input  logic [IndexWidth-1:0] rd_addr0_i,
  input  logic [IndexWidth-1:0] rd_addr1_i,
  output logic [NBitsR-1:0]     rd_sel0_o,
  output logic                  rd_live0_o,
  output logic [NBitsR-1:0]     rd_sel1_o,
  output logic                  rd_live1_o
);

  localparam int unsigned Depth = 2 ** IndexWidth;

  logic [NBitsR-1:0]     sel_q [Depth];
  logic [Depth-1:0]      live_q;
  logic [IndexWidth-1:0] rd_addr [2];
  logic [NBitsR-1:0]     rd_sel_d [2];
  logic [NBitsR-1:0]     rd_sel_q [2];
  logic [1:0]            rd_live_d, rd_live_q;

  assign rd_addr[0] = rd_addr0_i;
  assign rd_addr[1] = rd_addr1_i;

  // Same-edge writes bypass the array; port 1 is checked first so it wins.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_sel_d[p]  = sel_q[rd_addr[p]];
      rd_live_d[p] = live_q[rd_addr[p]];
      if (we1_i && addr1_i == rd_addr[p]) begin
        rd_sel_d[p]  = bank1_i;
        rd_live_d[p] = 1'b1;
      end else if (we0_i && addr0_i == rd_addr[p]) begin
        rd_sel_d[p]  = bank0_i;
        rd_live_d[p] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < Depth; i++) sel_q[i] <= '0;
      live_q    <= '0;
      rd_sel_q  <= '{default: '0};
      rd_live_q <= '0;
    end else begin
      if (we0_i) begin
        sel_q[addr0_i]  <= bank0_i;
        live_q[addr0_i] <= 1'b1;
      end
      // Later non-blocking assignment overrides port 0 on an address tie.
      if (we1_i) begin
        sel_q[addr1_i]  <= bank1_i;
        live_q[addr1_i] <= 1'b1;
      end
      rd_sel_q  <= rd_sel_d;
      rd_live_q <= rd_live_d;
    end
  end

  assign rd_sel0_o  = rd_sel_q[0];
  assign rd_live0_o = rd_live_q[0];
  assign rd_sel1_o  = rd_sel_q[1];
  assign rd_live1_o = rd_live_q[1];

endmodule

// File: rtl/lvt_bank_router.sv
// Steers two tagged write requests into R BRAM banks and tracks the latest bank per address.
module lvt_bank_router import lvt_pkg::*; #(
  parameter int unsigned IndexWidth = IndexWidthDef,
  parameter int unsigned DataWidth  = DataWidthDef,
  parameter int unsigned R          = RDef,
  parameter int unsigned NBitsR     = NBitsRDef
) (
  input logic          clk,
  input logic          reset,
  lvt_bank_router_if.slave bus
);

  localparam logic [NBitsR:0] BankLimit = (NBitsR + 1)'(R);

  logic                    valid0, valid1, same_bank, keep0;
  logic [R-1:0]            bank_we_d, bank_we_q;
  logic [R*IndexWidth-1:0] bank_addr_d, bank_addr_q;
  logic [R*DataWidth-1:0]  bank_wdata_d, bank_wdata_q;
  logic                    collision_d, collision_q;
  logic                    bank_err_d, bank_err_q;

  always_comb begin
    valid0    = bus.wr_en[0] && ({1'b0, bus.wr_bank0} < BankLimit);
    valid1    = bus.wr_en[1] && ({1'b0, bus.wr_bank1} < BankLimit);
    same_bank = valid0 && valid1 && (bus.wr_bank0 == bus.wr_bank1);
    keep0     = valid0 && !same_bank;

    collision_d = same_bank;
    bank_err_d  = (bus.wr_en[0] && !valid0) || (bus.wr_en[1] && !valid1);

    // Idle banks keep their last address/data; only the strobe drops.
    bank_we_d    = '0;
    bank_addr_d  = bank_addr_q;
    bank_wdata_d = bank_wdata_q;
    for (int unsigned k = 0; k < R; k++) begin
      if (keep0 && bus.wr_bank0 == NBitsR'(k)) begin
        bank_we_d[k]                             = 1'b1;
        bank_addr_d[k*IndexWidth +: IndexWidth]  = bus.wr_addr0;
        bank_wdata_d[k*DataWidth +: DataWidth]   = bus.wr_data0;
      end
      if (valid1 && bus.wr_bank1 == NBitsR'(k)) begin
        bank_we_d[k]                             = 1'b1;
        bank_addr_d[k*IndexWidth +: IndexWidth]  = bus.wr_addr1;
        bank_wdata_d[k*DataWidth +: DataWidth]   = bus.wr_data1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_we_q    <= '0;
      bank_addr_q  <= '0;
      bank_wdata_q <= '0;
      collision_q  <= 1'b0;
      bank_err_q   <= 1'b0;
    end else begin
      bank_we_q    <= bank_we_d;
      bank_addr_q  <= bank_addr_d;
      bank_wdata_q <= bank_wdata_d;
      collision_q  <= collision_d;
      bank_err_q   <= bank_err_d;
    end
  end

  assign bus.bank_we    = bank_we_q;
  assign bus.bank_addr  = bank_addr_q;
  assign bus.bank_wdata = bank_wdata_q;
  assign bus.collision  = collision_q;
  assign bus.bank_err   = bank_err_q;

  lvt_table #(
    .IndexWidth (IndexWidth),
    .NBitsR     (NBitsR)
  ) u_table (
    .clk        (clk),
    .reset      (reset),
    .we0_i      (keep0),
    .addr0_i    (bus.wr_addr0),
    .bank0_i    (bus.wr_bank0),
    .we1_i      (valid1),
    .addr1_i    (bus.wr_addr1),
    .bank1_i    (bus.wr_bank1),
    .rd_addr0_i (bus.rd_addr0),
    .rd_addr1_i (bus.rd_addr1),
    .rd_sel0_o  (bus.rd_sel0),
    .rd_live0_o (bus.rd_live0),
    .rd_sel1_o  (bus.rd_sel1),
    .rd_live1_o (bus.rd_live1)
  );

endmodule

// File: tb/tb_lvt_bank_router.sv
// Scoreboard bench for lvt_bank_router: an R=4 instance plus an R=3 instance for bad bank indices.
module tb_lvt_bank_router;

  localparam int unsigned IW = 8;
  localparam int unsigned DW = 32;

  typedef struct {
    string       name;
    logic [3:0]  we;
    int          bank;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        coll;
    logic        err;
  } wexp_t;

  typedef struct {
    string      name;
    int         port;
    logic [1:0] sel;
    logic       live;
  } rexp_t;

  wexp_t wq[$];
  rexp_t rq[$];
  int    passed = 0;
  int    total  = 0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lvt_bank_router_if #(.IndexWidth(IW), .DataWidth(DW), .R(4), .NBitsR(2)) bus ();
  lvt_bank_router_if #(.IndexWidth(IW), .DataWidth(DW), .R(3), .NBitsR(2)) bus3 ();

  lvt_bank_router #(.IndexWidth(IW), .DataWidth(DW), .R(4), .NBitsR(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  lvt_bank_router #(.IndexWidth(IW), .DataWidth(DW), .R(3), .NBitsR(2)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en  = 2'b00;
    bus3.wr_en = 2'b00;
  endtask

  task automatic drive(input logic [1:0] en, input logic [7:0] a0, input logic [1:0] b0,
                       input logic [31:0] d0, input logic [7:0] a1, input logic [1:0] b1,
                       input logic [31:0] d1);
    bus.wr_en = en;
    bus.wr_addr0 = a0; bus.wr_bank0 = b0; bus.wr_data0 = d0;
    bus.wr_addr1 = a1; bus.wr_bank1 = b1; bus.wr_data1 = d1;
  endtask

  task automatic test_reset();
    wexp_t w;
    rexp_t r;
    reset = 1'b0;
    idle();
    bus.rd_addr0 = 8'h10; bus.rd_addr1 = 8'h00;
    bus3.rd_addr0 = 8'h00; bus3.rd_addr1 = 8'h00;
    repeat (2) step();
    reset = 1'b1;
    wq.push_back('{"reset", 4'b0000, 0, 8'h00, 32'h0, 1'b0, 1'b0});
    rq.push_back('{"reset_rd", 0, 2'd0, 1'b0});
    step();
    w = wq.pop_front();
    r = rq.pop_front();
    total++; if (bus.bank_we !== w.we) $display("FAIL %s we: got %b want %b", w.name, bus.bank_we, w.we); else passed++;
    total++; if (bus.collision !== w.coll || bus.bank_err !== w.err) $display("FAIL %s flags: got %b%b want %b%b", w.name, bus.collision, bus.bank_err, w.coll, w.err); else passed++;
    total++; if (bus.rd_sel0 !== r.sel || bus.rd_live0 !== r.live) $display("FAIL %s: got sel %0d live %b want sel %0d live %b", r.name, bus.rd_sel0, bus.rd_live0, r.sel, r.live); else passed++;
  endtask

  task automatic test_single_write();
    wexp_t w;
    rexp_t r;
    drive(2'b01, 8'h10, 2'd2, 32'hA5A5A5A5, 8'h77, 2'd0, 32'h0);
    wq.push_back('{"single", 4'b0100, 2, 8'h10, 32'hA5A5A5A5, 1'b0, 1'b0});
    step();
    w = wq.pop_front();
    total++; if (bus.bank_we !== w.we) $display("FAIL %s we: got %b want %b", w.name, bus.bank_we, w.we); else passed++;
    total++; if (bus.bank_addr[w.bank*IW +: IW] !== w.addr) $display("FAIL %s addr: got %h want %h", w.name, bus.bank_addr[w.bank*IW +: IW], w.addr); else passed++;
    total++; if (bus.bank_wdata[w.bank*DW +: DW] !== w.data) $display("FAIL %s data: got %h want %h", w.name, bus.bank_wdata[w.bank*DW +: DW], w.data); else passed++;
    idle();
    bus.rd_addr0 = 8'h10;
    wq.push_back('{"single_hold", 4'b0000, 2, 8'h10, 32'hA5A5A5A5, 1'b0, 1'b0});
    rq.push_back('{"single_rd", 0, 2'd2, 1'b1});
    step();
    w = wq.pop_front();
    r = rq.pop_front();
    total++; if (bus.bank_we !== w.we) $display("FAIL %s we: got %b want %b", w.name, bus.bank_we, w.we); else passed++;
    total++; if (bus.bank_wdata[w.bank*DW +: DW] !== w.data) $display("FAIL %s data: got %h want %h", w.name, bus.bank_wdata[w.bank*DW +: DW], w.data); else passed++;
    total++; if (bus.rd_sel0 !== r.sel || bus.rd_live0 !== r.live) $display("FAIL %s: got sel %0d live %b want sel %0d live %b", r.name, bus.rd_sel0, bus.rd_live0, r.sel, r.live); else passed++;
  endtask

  task automatic test_same_bank();
    wexp_t w;
    rexp_t r;
    drive(2'b11, 8'h03, 2'd1, 32'h11111111, 8'h04, 2'd1, 32'h22222222);
    wq.push_back('{"same_bank", 4'b0010, 1, 8'h04, 32'h22222222, 1'b1, 1'b0});
    step();
    w = wq.pop_front();
    total++; if (bus.bank_we !== w.we) $display("FAIL %s we: got %b want %b", w.name, bus.bank_we, w.we); else passed++;
    total++; if (bus.bank_addr[w.bank*IW +: IW] !== w.addr) $display("FAIL %s addr: got %h want %h", w.name, bus.bank_addr[w.bank*IW +: IW], w.addr); else passed++;
    total++; if (bus.bank_wdata[w.bank*DW +: DW] !== w.data) $display("FAIL %s data: got %h want %h", w.name, bus.bank_wdata[w.bank*DW +: DW], w.data); else passed++;
    total++; if (bus.collision !== w.coll) $display("FAIL %s collision: got %b want %b", w.name, bus.collision, w.coll); else passed++;
    idle();
    bus.rd_addr0 = 8'h03; bus.rd_addr1 = 8'h04;
    wq.push_back('{"same_bank_after", 4'b0000, 1, 8'h04, 32'h22222222, 1'b0, 1'b0});
    rq.push_back('{"dropped_rd", 0, 2'd0, 1'b0});
    rq.push_back('{"winner_rd", 1, 2'd1, 1'b1});
    step();
    w = wq.pop_front();
    total++; if (bus.collision !== w.coll) $display("FAIL %s collision: got %b want %b", w.name, bus.collision, w.coll); else passed++;
    r = rq.pop_front();
    total++; if (bus.rd_sel0 !== r.sel || bus.rd_live0 !== r.live) $display("FAIL %s: got sel %0d live %b want sel %0d live %b", r.name, bus.rd_sel0, bus.rd_live0, r.sel, r.live); else passed++;
    r = rq.pop_front();
    total++; if (bus.rd_sel1 !== r.sel || bus.rd_live1 !== r.live) $display("FAIL %s: got sel %0d live %b want sel %0d live %b", r.name, bus.rd_sel1, bus.rd_live1, r.sel, r.live); else passed++;
  endtask

  task automatic test_same_addr();
    wexp_t w;
    rexp_t r;
    drive(2'b11, 8'h20, 2'd0, 32'hAAAA0000, 8'h20, 2'd3, 32'hBBBB3333);
    wq.push_back('{"same_addr_b0", 4'b1001, 0, 8'h20, 32'hAAAA0000, 1'b0, 1'b0});
    wq.push_back('{"same_addr_b3", 4'b1001, 3, 8'h20, 32'hBBBB3333, 1'b0, 1'b0});
    step();
    w = wq.pop_front();
    total++; if (bus.bank_we !== w.we) $display("FAIL %s we: got %b want %b", w.name, bus.bank_we, w.we); else passed++;
    total++; if (bus.collision !== w.coll) $display("FAIL %s collision: got %b want %b", w.name, bus.collision, w.coll); else passed++;
    total++; if (bus.bank_wdata[w.bank*DW +: DW] !== w.data) $display("FAIL %s data: got %h want %h", w.name, bus.bank_wdata[w.bank*DW +: DW], w.data); else passed++;
    w = wq.pop_front();
    total++; if (bus.bank_wdata[w.bank*DW +: DW] !== w.data) $display("FAIL %s data: got %h want %h", w.name, bus.bank_wdata[w.bank*DW +: DW], w.data); else passed++;
    idle();
    bus.rd_addr0 = 8'h20;
    rq.push_back('{"same_addr_rd", 0, 2'd3, 1'b1});
    step();
    r = rq.pop_front();
    total++; if (bus.rd_sel0 !== r.sel || bus.rd_live0 !== r.live) $display("FAIL %s: got sel %0d live %b want sel %0d live %b", r.name, bus.rd_sel0, bus.rd_live0, r.sel, r.live); else passed++;
  endtask

  task automatic test_bypass();
    rexp_t r;
    drive(2'b01, 8'h30, 2'd1, 32'h30303030, 8'h00, 2'd0, 32'h0);
    bus.rd_addr1 = 8'h30;
    rq.push_back('{"bypass_p0", 1, 2'd1, 1'b1});
    step();
    r = rq.pop_front();
    total++; if (bus.rd_sel1 !== r.sel || bus.rd_live1 !== r.live) $display("FAIL %s: got sel %0d live %b want sel %0d live %b", r.name, bus.rd_sel1, bus.rd_live1, r.sel, r.live); else passed++;
    drive(2'b11, 8'h40, 2'd0, 32'h40404040, 8'h40, 2'd2, 32'h42424242);
    bus.rd_addr0 = 8'h40; bus.rd_addr1 = 8'h40;
    rq.push_back('{"bypass_prio_rd0", 0, 2'd2, 1'b1});
    rq.push_back('{"bypass_prio_rd1", 1, 2'd2, 1'b1});
    step();
    r = rq.pop_front();
    total++; if (bus.rd_sel0 !== r.sel || bus.rd_live0 !== r.live) $display("FAIL %s: got sel %0d live %b want sel %0d live %b", r.name, bus.rd_sel0, bus.rd_live0, r.sel, r.live); else passed++;
    r = rq.pop_front();
    total++; if (bus.rd_sel1 !== r.sel || bus.rd_live1 !== r.live) $display("FAIL %s: got sel %0d live %b want sel %0d live %b", r.name, bus.rd_sel1, bus.rd_live1, r.sel, r.live); else passed++;
    idle();
  endtask

  task automatic test_back_to_back();
    wexp_t w;
    rexp_t r;
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      drive(2'b01, 8'(8'h50 + i), 2'(i % 4), d, 8'h00, 2'd0, 32'h0);
      wq.push_back('{"b2b", 4'(1 << (i % 4)), i % 4, 8'(8'h50 + i), d, 1'b0, 1'b0});
      step();
      w = wq.pop_front();
      total++; if (bus.bank_we !== w.we) $display("FAIL %s we[%0d]: got %b want %b", w.name, i, bus.bank_we, w.we); else passed++;
      total++; if (bus.bank_wdata[w.bank*DW +: DW] !== w.data) $display("FAIL %s data[%0d]: got %h want %h", w.name, i, bus.bank_wdata[w.bank*DW +: DW], w.data); else passed++;
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      bus.rd_addr0 = 8'(8'h50 + i);
      rq.push_back('{"b2b_rd", 0, 2'(i % 4), 1'b1});
      step();
      r = rq.pop_front();
      total++; if (bus.rd_sel0 !== r.sel || bus.rd_live0 !== r.live) $display("FAIL %s[%0d]: got sel %0d live %b want sel %0d live %b", r.name, i, bus.rd_sel0, bus.rd_live0, r.sel, r.live); else passed++;
    end
  endtask

  task automatic test_bank_err();
    wexp_t w;
    rexp_t r;
    bus3.wr_en = 2'b11;
    bus3.wr_addr0 = 8'h10; bus3.wr_bank0 = 2'd3; bus3.wr_data0 = 32'hDEADBEEF;
    bus3.wr_addr1 = 8'h11; bus3.wr_bank1 = 2'd2; bus3.wr_data1 = 32'h12121212;
    wq.push_back('{"bank_err", 4'b0100, 2, 8'h11, 32'h12121212, 1'b0, 1'b1});
    step();
    w = wq.pop_front();
    total++; if (bus3.bank_we !== w.we[2:0]) $display("FAIL %s we: got %b want %b", w.name, bus3.bank_we, w.we[2:0]); else passed++;
    total++; if (bus3.bank_err !== w.err) $display("FAIL %s err: got %b want %b", w.name, bus3.bank_err, w.err); else passed++;
    total++; if (bus3.collision !== w.coll) $display("FAIL %s collision: got %b want %b", w.name, bus3.collision, w.coll); else passed++;
    idle();
    bus3.rd_addr0 = 8'h10; bus3.rd_addr1 = 8'h11;
    wq.push_back('{"bank_err_after", 4'b0000, 0, 8'h00, 32'h0, 1'b0, 1'b0});
    rq.push_back('{"bad_bank_rd", 0, 2'd0, 1'b0});
    rq.push_back('{"good_bank_rd", 1, 2'd2, 1'b1});
    step();
    w = wq.pop_front();
    total++; if (bus3.bank_err !== w.err) $display("FAIL %s err: got %b want %b", w.name, bus3.bank_err, w.err); else passed++;
    r = rq.pop_front();
    total++; if (bus3.rd_sel0 !== r.sel || bus3.rd_live0 !== r.live) $display("FAIL %s: got sel %0d live %b want sel %0d live %b", r.name, bus3.rd_sel0, bus3.rd_live0, r.sel, r.live); else passed++;
    r = rq.pop_front();
    total++; if (bus3.rd_sel1 !== r.sel || bus3.rd_live1 !== r.live) $display("FAIL %s: got sel %0d live %b want sel %0d live %b", r.name, bus3.rd_sel1, bus3.rd_live1, r.sel, r.live); else passed++;
  endtask

  task automatic test_reset_mid();
    wexp_t w;
    rexp_t r;
    logic [7:0] addrs [5];
    addrs = '{8'h10, 8'h20, 8'h30, 8'h60, 8'h04};
    drive(2'b01, 8'h60, 2'd2, 32'h600D600D, 8'h00, 2'd0, 32'h0);
    wq.push_back('{"pre_reset", 4'b0100, 2, 8'h60, 32'h600D600D, 1'b0, 1'b0});
    step();
    w = wq.pop_front();
    total++; if (bus.bank_we !== w.we) $display("FAIL %s we: got %b want %b", w.name, bus.bank_we, w.we); else passed++;
    reset = 1'b0;
    wq.push_back('{"mid_reset", 4'b0000, 2, 8'h00, 32'h0, 1'b0, 1'b0});
    #1;
    w = wq.pop_front();
    total++; if (bus.bank_we !== w.we) $display("FAIL %s we: got %b want %b", w.name, bus.bank_we, w.we); else passed++;
    total++; if (bus.bank_wdata[w.bank*DW +: DW] !== w.data) $display("FAIL %s data: got %h want %h", w.name, bus.bank_wdata[w.bank*DW +: DW], w.data); else passed++;
    idle();
    step();
    reset = 1'b1;
    foreach (addrs[i]) begin
      bus.rd_addr0 = addrs[i];
      rq.push_back('{"post_reset_rd", 0, 2'd0, 1'b0});
      step();
      r = rq.pop_front();
      total++; if (bus.rd_sel0 !== r.sel || bus.rd_live0 !== r.live) $display("FAIL %s[%h]: got sel %0d live %b want sel %0d live %b", r.name, addrs[i], bus.rd_sel0, bus.rd_live0, r.sel, r.live); else passed++;
    end
  endtask

  initial begin
    bus.wr_en = 2'b00;
    bus.wr_addr0 = '0; bus.wr_addr1 = '0; bus.wr_data0 = '0; bus.wr_data1 = '0;
    bus.wr_bank0 = '0; bus.wr_bank1 = '0; bus.rd_addr0 = '0; bus.rd_addr1 = '0;
    bus3.wr_en = 2'b00;
    bus3.wr_addr0 = '0; bus3.wr_addr1 = '0; bus3.wr_data0 = '0; bus3.wr_data1 = '0;
    bus3.wr_bank0 = '0; bus3.wr_bank1 = '0; bus3.rd_addr0 = '0; bus3.rd_addr1 = '0;
    test_reset();
    test_single_write();
    test_same_bank();
    test_same_addr();
    test_bypass();
    test_back_to_back();
    test_bank_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lvt_bank_router.md
Name: lvt_bank_router

Overview:
- Downstream stage of the valid/replacement-count array in the LVT multi-ported memory.
- Receives up to two write requests per cycle, each already tagged with a target BRAM bank index by the count array.
- Steers each write into one of R BRAM banks through registered per-bank write strobes, and records the bank in a live value table (LVT).
- Answers two read ports with the bank holding the latest value for an address.

Parameters:
- index_width, 8, address width; LVT depth = 2**index_width.
- data_width, 32, write data width.
- r, 4, number of BRAM banks.
- n_bits_r, 2, bank index width; must satisfy 2**n_bits_r >= r.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  2  write request per port; bit i = port i.
- wr_addr0, wr_addr1  in  index_width each  write addresses.
- wr_data0, wr_data1  in  data_width each  write data.
- wr_bank0, wr_bank1  in  n_bits_r each  bank index from count array, aligned with wr_en.
- bank_we  out  r  per-bank write strobe, registered.
- bank_addr  out  r*index_width  per-bank address; slice k = bank k.
- bank_wdata  out  r*data_width  per-bank data; slice k = bank k.
- rd_addr0, rd_addr1  in  index_width each  LVT lookup addresses.
- rd_sel0, rd_sel1  out  n_bits_r each  bank holding latest value.
- rd_live0, rd_live1  out  1 each  address written since reset.
- collision  out  1  pulse: port 0 write dropped.
- bank_err  out  1  pulse: a bank index >= r was received.

Behaviour:
- Reset (asynchronous, active-low):
  - All LVT entries cleared to 0; all live bits cleared.
  - bank_we, bank_addr, bank_wdata, rd_sel*, rd_live*, collision and bank_err all go to 0.
- Write path, one-cycle latency:
  - A request sampled at edge T appears on bank_we/bank_addr/bank_wdata after edge T, and is held for exactly one cycle.
  - bank_addr and bank_wdata slices hold their last value while the corresponding bank_we bit is 0.
- Port validity: port i is valid when wr_en[i]=1 and wr_bank_i < r.
  - An invalid bank index drops that port's write, leaves the LVT unchanged, and pulses bank_err for one cycle.
- Same-bank conflict (both ports valid, wr_bank0 == wr_bank1):
  - Port 1 wins; port 0 is dropped; collision pulses.
- Same-address conflict (both ports valid, wr_addr0 == wr_addr1, different banks):
  - Both banks are written.
  - LVT records port 1's bank (port 1 has priority), so reads return port 1's data.
  - collision does not pulse.
- LVT update:
  - On edge T, each surviving write sets LVT[addr] = its bank and live[addr] = 1.
  - Port 1 is applied after port 0.
- Read path, one-cycle registered latency:
  - rd_addrX sampled at edge T gives rd_selX and rd_liveX after T.
  - Write-to-read bypass: if a surviving write to the same address is sampled at the same edge T, rd_sel returns the new bank and rd_live=1. Port 1 takes priority over port 0.
- rd_live=0 implies rd_sel=0.
- Reset mid-operation: in-flight bank strobes are cancelled immediately; no partial write survives.
- No backpressure: the block accepts one write per port every cycle.

Decomposition:
- Shared package lvt_pkg:
  - defaults for index_width, data_width, r, n_bits_r;
  - function clog2;
  - port priority constant PORT_PRIO = 1.
- Sub-module lvt_table:
  - 2W/2R storage of n_bits_r bank index plus live bit;
  - asynchronous clear;
  - registered reads with internal write bypass.
- lvt_bank_router holds conflict resolution and the per-bank output registers.

Test Plan:
- Reset then read addr 0x10 -> rd_sel0=0, rd_live0=0; bank_we=0.
- wr_en=01, addr0=0x10, bank0=2, data0=0xA5A5A5A5 -> next cycle:
  - bank_we=0100;
  - bank_addr slice 2 = 0x10;
  - bank_wdata slice 2 = 0xA5A5A5A5.
  Then read 0x10 -> rd_sel=2, rd_live=1.
- wr_en=11, both bank=1, addr0=0x03, addr1=0x04 -> bank_we=0010 carrying port-1 data; collision=1; LVT[0x04]=1; LVT[0x03] unchanged/not live.
- wr_en=11, both addr=0x20, bank0=0, bank1=3 -> bank_we=1001; collision=0; then read 0x20 -> rd_sel=3.
- Same-cycle write addr 0x30 bank 1 and read rd_addr1=0x30 -> next cycle rd_sel1=1, rd_live1=1 (bypass).
- Sub-case (r=3 build): wr_bank0=3 -> bank_err=1; bank_we=0; LVT unchanged.
- Assert reset while bank_we=0100 -> bank_we=0 immediately; every LVT read returns live=0 after release.
